// File: rtl/alu_exec_if.sv
// Handshake and operand/result bundle between the ID/EX boundary, the execute ALU and its consumer.
// The producer/consumer side uses master; the ALU uses slave.
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             invA;
    logic             invB;
    logic             sign;
    logic [2:0]       op_to_alu;
    logic             cin;
    logic             passA;
    logic             passB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             ofl;
    logic             cout;

    modport master (
        output in_valid, A, B, invA, invB, sign, op_to_alu, cin, passA, passB, out_ready,
        input  in_ready, out_valid, result, zero, neg, ofl, cout
    );

    modport slave (
        input  in_valid, A, B, invA, invB, sign, op_to_alu, cin, passA, passB, out_ready,
        output in_ready, out_valid, result, zero, neg, ofl, cout
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/pass, iterative 1-bit-per-cycle shifter/rotator,
// valid/ready on both sides with a registered result that holds under backpressure.
module alu_exec #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_exec_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   work_p1;
    logic [SHAMT_W-1:0] count_p1;
    logic [1:0]         sh_op_p1;
    logic [WIDTH-1:0]   result_p1;
    logic               zero_p1;
    logic               neg_p1;
    logic               ofl_p1;
    logic               cout_p1;

    logic [WIDTH-1:0]   ain;
    logic [WIDTH-1:0]   bin;
    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               start_shift;
    logic               accept;
    logic [WIDTH-1:0]   shift_next;
    logic [WIDTH+1:0]   add_res;
    logic [WIDTH-1:0]   imm_res;
    logic               imm_ofl;
    logic               imm_cout;

    // One step of the iterative shifter; op[1] picks direction, op[0] picks logical vs rotate.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            2'b01:   r = {v[WIDTH-2:0], 1'b0};
            2'b10:   r = {v[0], v[WIDTH-1:1]};
            default: r = {1'b0, v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Returns {ofl, cout, sum}; signed overflow only when both operands share a sign the sum lacks.
    function automatic logic [WIDTH+1:0] add_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             ci,
        input logic             sg
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [WIDTH:0]          full;
        logic                    ov;
        a_s  = $signed(a);
        b_s  = $signed(b);
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        if (sg) begin
            ov = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (full[WIDTH-1] != a_s[WIDTH-1]);
        end else begin
            ov = full[WIDTH];
        end
        return {ov, full};
    endfunction

    assign ain         = bus.invA ? ~bus.A : bus.A;
    assign bin         = bus.invB ? ~bus.B : bus.B;
    assign shamt       = bus.B[SHAMT_W-1:0];
    assign is_shift    = !bus.passA && !bus.passB && !bus.op_to_alu[2];
    assign start_shift = is_shift && (shamt != '0);
    assign accept      = bus.in_valid && bus.in_ready;
    assign shift_next  = shift1(work_p1, sh_op_p1);
    assign add_res     = add_op(ain, bin, bus.cin, bus.sign);

    // Single-cycle result; a zero-distance shift falls through as Ain.
    always_comb begin
        imm_res  = ain;
        imm_ofl  = 1'b0;
        imm_cout = 1'b0;
        if (bus.passA) begin
            imm_res = ain;
        end else if (bus.passB) begin
            imm_res = bin;
        end else begin
            case (bus.op_to_alu)
                3'b100:  {imm_ofl, imm_cout, imm_res} = add_res;
                3'b101:  imm_res = ain | bin;
                3'b110:  imm_res = ain ^ bin;
                3'b111:  imm_res = ain & bin;
                default: imm_res = ain;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = start_shift ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                if (count_p1 <= SHAMT_W'(1)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = start_shift ? SHIFT : HOLD;
                end else if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: operand capture at accept, iterative shift, and final result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p1  <= '0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            neg_p1    <= 1'b0;
            ofl_p1    <= 1'b0;
            cout_p1   <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                work_p1  <= ain;
                count_p1 <= shamt;
                sh_op_p1 <= bus.op_to_alu[1:0];
            end else begin
                result_p1 <= imm_res;
                zero_p1   <= (imm_res == '0);
                neg_p1    <= imm_res[WIDTH-1];
                ofl_p1    <= imm_ofl;
                cout_p1   <= imm_cout;
            end
        end else if (state == SHIFT) begin
            work_p1  <= shift_next;
            count_p1 <= count_p1 - SHAMT_W'(1);
            if (count_p1 <= SHAMT_W'(1)) begin
                result_p1 <= shift_next;
                zero_p1   <= (shift_next == '0);
                neg_p1    <= shift_next[WIDTH-1];
                ofl_p1    <= 1'b0;
                cout_p1   <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign bus.out_valid = (state == HOLD);
    assign bus.result    = result_p1;
    assign bus.zero      = zero_p1;
    assign bus.neg       = neg_p1;
    assign bus.ofl       = ofl_p1;
    assign bus.cout      = cout_p1;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomized bench for alu_exec against a plain-arithmetic reference model.
module tb_alu_exec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(16)) bus ();

    alu_exec #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        o;
        logic        c;
        logic [7:0]  lat;
    } exp_t;

    function automatic exp_t model(
        input logic [15:0] a, b,
        input logic ia, ib, sg,
        input logic [2:0] op,
        input logic ci, pa, pb
    );
        exp_t e;
        logic [15:0] ain, bin;
        int n, s, sa;
        ain = ia ? ~a : a;
        bin = ib ? ~b : b;
        n   = int'(b[3:0]);
        e   = '0;
        e.lat = 8'd1;
        if (pa) e.r = ain;
        else if (pb) e.r = bin;
        else begin
            case (op)
                3'b000: e.r = (ain << n) | (ain >> (16 - n));
                3'b001: e.r = ain << n;
                3'b010: e.r = (ain >> n) | (ain << (16 - n));
                3'b011: e.r = ain >> n;
                3'b100: begin
                    s    = int'(ain) + int'(bin) + int'(ci);
                    sa   = int'($signed(ain)) + int'($signed(bin)) + int'(ci);
                    e.r  = s[15:0];
                    e.c  = (s > 65535);
                    e.o  = sg ? ((sa > 32767) || (sa < -32768)) : e.c;
                end
                3'b101: e.r = ain | bin;
                3'b110: e.r = ain ^ bin;
                default: e.r = ain & bin;
            endcase
            if (!op[2] && n != 0) e.lat = 8'(n + 1);
        end
        e.z = (e.r == 16'h0000);
        e.n = e.r[15];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(
        input logic [15:0] a, b,
        input logic ia, ib, sg,
        input logic [2:0] op,
        input logic ci, pa, pb
    );
        bus.A = a; bus.B = b; bus.invA = ia; bus.invB = ib; bus.sign = sg;
        bus.op_to_alu = op; bus.cin = ci; bus.passA = pa; bus.passB = pb;
        bus.in_valid = 1'b1;
    endtask

    task automatic scramble();
        bus.in_valid = 1'b0;
        bus.A = 16'($urandom); bus.B = 16'($urandom);
        bus.invA = 1'($urandom); bus.invB = 1'($urandom); bus.sign = 1'($urandom);
        bus.op_to_alu = 3'($urandom); bus.cin = 1'($urandom);
        bus.passA = 1'($urandom); bus.passB = 1'($urandom);
    endtask

    // Issues one op from IDLE, then checks latency, busy in_ready, result, flags and hold stability.
    task automatic run_op(
        input logic [15:0] a, b,
        input logic ia, ib, sg,
        input logic [2:0] op,
        input logic ci, pa, pb,
        input int hold,
        input logic [16:0] lit
    );
        exp_t e;
        int lat;
        e = model(a, b, ia, ib, sg, op, ci, pa, pb);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        drive(a, b, ia, ib, sg, op, ci, pa, pb);
        @(posedge clk);
        @(negedge clk);
        scramble();
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(e.lat));
        check("result", 32'(bus.result), 32'(e.r));
        check("zero", 32'(bus.zero), 32'(e.z));
        check("neg", 32'(bus.neg), 32'(e.n));
        check("ofl", 32'(bus.ofl), 32'(e.o));
        check("cout", 32'(bus.cout), 32'(e.c));
        if (lit[16]) check("result_const", 32'(bus.result), 32'(lit[15:0]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_result", 32'(bus.result), 32'(e.r));
            check("hold_flags", {28'd0, bus.zero, bus.neg, bus.ofl, bus.cout},
                  {28'd0, e.z, e.n, e.o, e.c});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("released", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", {28'd0, bus.zero, bus.neg, bus.ofl, bus.cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Signed add overflow, subtraction both ways
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1, {1'b1, 16'h8000});
        run_op(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 0, {1'b1, 16'hFFFE});
        run_op(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 0, {1'b1, 16'h0002});
        // Shifts, including the longest one and a zero-distance shift
        run_op(16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, {1'b1, 16'h0018});
        run_op(16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 0, {1'b1, 16'h0001});
        run_op(16'h1234, 16'h000F, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, {1'b1, 16'h091A});
        run_op(16'hA5A5, 16'h0010, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 0, {1'b1, 16'hA5A5});
        // Logic and pass paths
        run_op(16'hF0F0, 16'hFF00, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 0, {1'b1, 16'h00F0});
        run_op(16'h5555, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 0, {1'b1, 16'h1234});
        run_op(16'h00AA, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 0, {1'b1, 16'h00AA});

        // Backpressure on an add, then back-to-back XOR accepted as HOLD releases
        check("bp_in_ready", 32'(bus.in_ready), 32'd1);
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        scramble();
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp_result", 32'(bus.result), 32'h8000);
            check("bp_flags", {28'd0, bus.zero, bus.neg, bus.ofl, bus.cout}, 32'b0110);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        drive(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0);
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        scramble();
        bus.out_ready = 1'b0;
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_result", 32'(bus.result), 32'h0000);
        check("b2b_zero", 32'(bus.zero), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b_released", 32'(bus.out_valid), 32'd0);

        // Leave a nonzero result behind, then reset in the third SHIFT cycle
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 0, {1'b1, 16'h8000});
        drive(16'hFFFF, 16'h000F, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        scramble();
        @(negedge clk);
        @(negedge clk);
        check("mid_shift_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_result", 32'(bus.result), 32'd0);
        check("mrst_flags", {28'd0, bus.zero, bus.neg, bus.ofl, bus.cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_idle", 32'(bus.out_valid), 32'd0);
        repeat (20) begin
            @(negedge clk);
            check("mrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Randomized operations against the reference model
        for (int k = 0; k < 80; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   3'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 2)), 17'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
